// File: rtl/op_encoder32.sv
// One-hot to 3-bit operation-code encoder with a 2-entry output FIFO and a
// sticky, saturating illegal-input counter.
module op_encoder32 #(
  parameter int ERR_CNT_W = 8,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           In,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 A0,
  output logic                 A1,
  output logic                 A2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 err_clr
);

  localparam logic [1:0] FULL = 2'(DEPTH);
  localparam logic [ERR_CNT_W-1:0] ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  // Returns {legal, code}; anything not exactly one of bits 0..4 is illegal.
  function automatic logic [3:0] encode(input logic [7:0] v);
    case (v)
      8'h01:   encode = {1'b1, 3'b000};
      8'h02:   encode = {1'b1, 3'b001};
      8'h04:   encode = {1'b1, 3'b010};
      8'h08:   encode = {1'b1, 3'b100};
      8'h10:   encode = {1'b1, 3'b101};
      default: encode = {1'b0, 3'b000};
    endcase
  endfunction

  logic [2:0]           mem_q [0:1];
  logic [1:0]           cnt_q, cnt_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 rdy_q;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 push, pop, legal, wr;
  logic [2:0]           code;
  logic [2:0]           head;

  // in_ready is held low until the first edge after reset release.
  assign in_ready  = rdy_q & (cnt_q != FULL);
  assign out_valid = (cnt_q != 2'd0);
  assign head      = out_valid ? mem_q[rd_ptr_q] : 3'b000;
  assign {A2, A1, A0} = head;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

  always_comb begin
    push          = in_valid & in_ready;
    pop           = out_valid & out_ready;
    {legal, code} = encode(In);
    wr            = push & legal;
    cnt_d         = cnt_q;
    case ({wr, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    wr_ptr_d  = wr_ptr_q ^ wr;
    rd_ptr_d  = rd_ptr_q ^ pop;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_d     = 1'b0;
      err_cnt_d = '0;
    end else if (push && !legal) begin
      err_d = 1'b1;
      if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rdy_q     <= 1'b1;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Storage carries no reset; the head is masked to 000 whenever empty.
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= code;
  end

endmodule

// File: tb/tb_op_encoder32.sv
// Directed self-checking bench for op_encoder32.
module tb_op_encoder32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] In;
  logic       in_valid;
  logic       in_ready;
  logic       A0, A1, A2;
  logic       out_valid;
  logic       out_ready;
  logic       err;
  logic [7:0] err_cnt;
  logic       err_clr;
  logic [2:0] code;

  int tests = 0;
  int fails = 0;

  assign code = {A2, A1, A0};

  always #5 clk = ~clk;

  op_encoder32 #(.ERR_CNT_W(8), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .In(In), .in_valid(in_valid), .in_ready(in_ready),
    .A0(A0), .A1(A1), .A2(A2), .out_valid(out_valid), .out_ready(out_ready),
    .err(err), .err_cnt(err_cnt), .err_clr(err_clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; In = 8'h00; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    step(); step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests++; if (code !== 3'b000) begin fails++; $display("FAIL reset_code got %b exp 000", code); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", err); end
    tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    rst_n = 1'b1;
    step();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_single();
    In = 8'h10; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %b exp 1", out_valid); end
    tests++; if (code !== 3'b101) begin fails++; $display("FAIL single_code got %b exp 101", code); end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_empty got %b exp 0", out_valid); end
    tests++; if (code !== 3'b000) begin fails++; $display("FAIL single_empty_code got %b exp 000", code); end
    // pop while empty must be harmless
    step();
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL pop_empty got valid=%b rdy=%b exp 0/1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0; in_valid = 1'b1; In = 8'h02;
    step();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_rdy1 got %b exp 1", in_ready); end
    In = 8'h08;
    step();
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_full got %b exp 0", in_ready); end
    tests++; if (code !== 3'b001) begin fails++; $display("FAIL b2b_head0 got %b exp 001", code); end
    In = 8'h04;
    step();
    tests++; if (code !== 3'b001 || out_valid !== 1'b1) begin fails++; $display("FAIL b2b_hold got %b/%b exp 001/1", code, out_valid); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_held_rdy got %b exp 0", in_ready); end
    out_ready = 1'b1;
    step();
    tests++; if (code !== 3'b100) begin fails++; $display("FAIL b2b_head1 got %b exp 100", code); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_rdy2 got %b exp 1", in_ready); end
    step();
    in_valid = 1'b0;
    tests++; if (code !== 3'b010 || out_valid !== 1'b1) begin fails++; $display("FAIL b2b_head2 got %b/%b exp 010/1", code, out_valid); end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_illegal();
    logic [7:0] bad [3];
    bad[0] = 8'h00; bad[1] = 8'h03; bad[2] = 8'h20;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      In = bad[i];
      step();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL illegal_fwd[%0d] got %b exp 0", i, out_valid); end
      tests++; if (err_cnt !== 8'(i + 1) || err !== 1'b1) begin fails++; $display("FAIL illegal_cnt[%0d] got %0d/%b exp %0d/1", i, err_cnt, err, i + 1); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_saturate();
    In = 8'h80; in_valid = 1'b1;
    for (int i = 0; i < 256 + 5; i++) @(posedge clk);
    #1;
    tests++; if (err_cnt !== 8'd255) begin fails++; $display("FAIL sat_cnt got %0d exp 255", err_cnt); end
    err_clr = 1'b1;
    step();
    tests++; if (err !== 1'b0 || err_cnt !== 8'd0) begin fails++; $display("FAIL clr_override got %b/%0d exp 0/0", err, err_cnt); end
    // legal push while clearing still reaches the FIFO
    In = 8'h01;
    step();
    err_clr = 1'b0; in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || code !== 3'b000) begin fails++; $display("FAIL clr_fifo got %b/%b exp 1/000", out_valid, code); end
    step();
  endtask

  task automatic test_illegal_with_pop();
    out_ready = 1'b0; in_valid = 1'b1; In = 8'h08;
    step();
    out_ready = 1'b1; In = 8'h00;
    step();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ill_pop_valid got %b exp 0", out_valid); end
    tests++; if (err !== 1'b1 || err_cnt !== 8'd1) begin fails++; $display("FAIL ill_pop_err got %b/%0d exp 1/1", err, err_cnt); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; In = 8'h02;
    step();
    In = 8'h04;
    step();
    in_valid = 1'b0;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL mid_full got %b exp 0", in_ready); end
    rst_n = 1'b0;
    step();
    tests++; if (out_valid !== 1'b0 || code !== 3'b000) begin fails++; $display("FAIL mid_reset got %b/%b exp 0/000", out_valid, code); end
    tests++; if (err !== 1'b0 || err_cnt !== 8'd0) begin fails++; $display("FAIL mid_reset_err got %b/%0d exp 0/0", err, err_cnt); end
    rst_n = 1'b1;
    step();
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL mid_release got %b/%b exp 1/0", in_ready, out_valid); end
    out_ready = 1'b1; in_valid = 1'b1; In = 8'h01;
    step();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || code !== 3'b000) begin fails++; $display("FAIL mid_first got %b/%b exp 1/000", out_valid, code); end
    step();
  endtask

  task automatic test_stream();
    logic [7:0] vin [8];
    logic [2:0] vexp [8];
    vin[0] = 8'h01; vexp[0] = 3'b000;
    vin[1] = 8'h02; vexp[1] = 3'b001;
    vin[2] = 8'h04; vexp[2] = 3'b010;
    vin[3] = 8'h08; vexp[3] = 3'b100;
    vin[4] = 8'h10; vexp[4] = 3'b101;
    vin[5] = 8'h01; vexp[5] = 3'b000;
    vin[6] = 8'h10; vexp[6] = 3'b101;
    vin[7] = 8'h08; vexp[7] = 3'b100;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      In = vin[i];
      step();
      tests++; if (out_valid !== 1'b1 || code !== vexp[i] || in_ready !== 1'b1) begin
        fails++; $display("FAIL stream[%0d] got v=%b c=%b r=%b exp 1/%b/1", i, out_valid, code, in_ready, vexp[i]);
      end
    end
    in_valid = 1'b0;
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_drain got %b exp 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_illegal();
    test_saturate();
    test_illegal_with_pop();
    test_reset_mid();
    test_stream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/op_encoder32.md
OP_ENCODER32 -- requirements
Module: op_encoder32

Interface
REQ-001 Parameter ERR_CNT_W, default 8, width of the saturating illegal-input counter.
REQ-002 Parameter DEPTH, default 2, output buffer entries; only the value 2 is supported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset is synchronous and active-low.
REQ-005 In  input  8  one-hot operation-select lines (decoded form).
REQ-006 in_valid  input  1  In is presented this cycle.
REQ-007 in_ready  output  1  block accepts In this cycle.
REQ-008 A0, A1, A2  output  1 each  encoded select code of the buffer head entry.
REQ-009 out_valid  output  1  A0..A2 hold a valid code.
REQ-010 out_ready  input  1  consumer takes the head entry this cycle.
REQ-011 err  output  1  sticky flag, set by any illegal input.
REQ-012 err_cnt  output  ERR_CNT_W  count of illegal inputs, saturating.
REQ-013 err_clr  input  1  clears err and err_cnt.

Function
REQ-014 Accept event (push) SHALL occur when in_valid & in_ready; pop SHALL occur when out_valid & out_ready.
REQ-015 Legal encoding (A2 A1 A0) SHALL be: In=8'h01 -> 000; 8'h02 -> 001; 8'h04 -> 010; 8'h08 -> 100; 8'h10 -> 101.
REQ-016 Any other In value at a push SHALL be illegal: zero, multi-hot, or bits 5-7 set.
REQ-017 An illegal push SHALL be consumed and dropped, with nothing written to the buffer.
REQ-018 An illegal push SHALL set err the next cycle and increment err_cnt by 1.
REQ-019 err_cnt SHALL saturate at all-ones with no wrap.
REQ-020 A legal push SHALL write its 3-bit code into a 2-entry FIFO.
REQ-021 When the FIFO is empty, the code SHALL appear on A0..A2 with out_valid=1 on the cycle after the push (latency 1); there is no combinational in-to-out path.
REQ-022 in_ready SHALL be 1 iff the FIFO holds fewer than 2 entries; it is a registered-state function and does not depend on out_ready.
REQ-023 A0..A2 SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 When push and pop occur in the same cycle with the FIFO holding 1 entry, occupancy SHALL stay 1 and the new code SHALL become head next cycle.
REQ-025 An illegal push in the same cycle as a pop SHALL cause only the pop to change occupancy.
REQ-026 Push with in_ready=0 SHALL NOT be possible, so the buffer has no overflow path.
REQ-027 Pop with out_valid=0 SHALL have no effect.
REQ-028 When empty, out_valid SHALL be 0 and A0..A2 SHALL read 000.
REQ-029 Read and write pointers SHALL wrap modulo 2.
REQ-030 When err_clr=1, err and err_cnt SHALL be 0 next cycle, overriding a simultaneous illegal push, which is not counted.
REQ-031 FIFO operation SHALL be unaffected by err_clr.

Reset
REQ-032 While rst_n=0 at a clock edge: FIFO emptied, out_valid=0, A0..A2=000, err=0, err_cnt=0.
REQ-033 While rst_n=0, in_ready SHALL be 0; it is 1 from the first cycle after rst_n returns high.
REQ-034 Reset asserted mid-operation SHALL discard buffered entries with no pop required.
REQ-035 Reset has no asynchronous effect; outputs change only at clock edges.

Verification
REQ-036 Single legal push of In=8'h10 with out_ready=1 -> next cycle out_valid=1, {A2,A1,A0}=101, then empty.
REQ-037 Push 8'h02, 8'h08, 8'h04 back-to-back with out_ready=0 -> in_ready=0 after the second push; the third is held until out_ready=1, at which point heads appear in order 001, 100, 010.
REQ-038 Push 8'h00, 8'h03, 8'h20 -> nothing forwarded, out_valid stays 0, err=1, err_cnt=3.
REQ-039 2^ERR_CNT_W+5 illegal pushes -> err_cnt=255 (default width); then err_clr=1 together with an illegal push -> err=0, err_cnt=0.
REQ-040 Two entries buffered, then rst_n=0 for one cycle -> out_valid=0, A0..A2=000, in_ready=1 after release, and the first subsequent push of 8'h01 is output as 000.
REQ-041 Continuous stream with out_ready=1 every cycle -> one code per cycle, occupancy never exceeds 1, in_ready constantly 1.
